// File: rtl/param_seq_alu.sv
// param_seq_alu: registered ALU with a valid/ready handshake on both sides.
// ADD/SUB/NEGA/NEGB/AND/OR/XOR finish in one cycle. MUL is an unsigned
// W-cycle shift-add. The result and its flags are held until the consumer
// takes them.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode present      in_ready   can accept this cycle
//   op[2:0]    0 ADD 1 SUB 2 NEGA 3 NEGB 4 MUL 5 AND 6 OR 7 XOR
//   a, b [W]   operands
//   out_valid  result/flags valid           out_ready  consumer takes result
//   result[2W] result; W-bit ops are zero-extended
//   flag_carry ADD carry-out / SUB borrow
//   flag_ovf   signed overflow (ADD/SUB/NEG), upper half nonzero (MUL)
//   flag_zero  result == 0
//
// state  | meaning
// S_IDLE | no result held
// S_MUL  | shift-add multiply in progress
// S_DONE | result held until out_ready
module param_seq_alu #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           flag_carry,
  output logic           flag_ovf,
  output logic           flag_zero
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NEGA = 3'd2;
  localparam logic [2:0] OP_NEGB = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [2*W-1:0] mcand, mcand_n;
  logic [2*W-1:0] acc, acc_n, acc_sum;
  logic [W-1:0]   mplier, mplier_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2*W-1:0] result_n;
  logic           carry_n, ovf_n, zero_n;
  logic           accept;

  logic [W:0]     sum_ext, diff_ext;
  logic [W-1:0]   alu_res;
  logic           alu_c, alu_v;

  // out_ready feeds in_ready combinationally so a held result can be
  // replaced by a new one on the same edge.
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // Carry out of a + ~b + 1 is set when no borrow occurs (a >= b).
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
  assign acc_sum  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[W-1:0];
        alu_c   = sum_ext[W];
        alu_v   = (a[W-1] == b[W-1]) && (alu_res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[W-1:0];
        alu_c   = ~diff_ext[W];
        alu_v   = (a[W-1] != b[W-1]) && (alu_res[W-1] != a[W-1]);
      end
      OP_NEGA: begin
        alu_res = '0 - a;
        alu_v   = (a == MOST_NEG);
      end
      OP_NEGB: begin
        alu_res = '0 - b;
        alu_v   = (b == MOST_NEG);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    result_n = result;
    carry_n  = flag_carry;
    ovf_n    = flag_ovf;
    zero_n   = flag_zero;
    case (state)
      S_IDLE, S_DONE: begin
        if ((state == S_DONE) && out_ready) state_n = S_IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_n  = {{W{1'b0}}, a};
            mplier_n = b;
            acc_n    = '0;
            cnt_n    = '0;
            state_n  = S_MUL;
          end else begin
            result_n = {{W{1'b0}}, alu_res};
            carry_n  = alu_c;
            ovf_n    = alu_v;
            zero_n   = (alu_res == '0);
            state_n  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_n    = acc_sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        // The last partial product is folded in on the same edge.
        if (cnt_n == CW'(W)) begin
          result_n = acc_sum;
          carry_n  = 1'b0;
          ovf_n    = |acc_sum[2*W-1:W];
          zero_n   = (acc_sum == '0);
          state_n  = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      result     <= '0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_zero  <= 1'b0;
    end else begin
      mcand      <= mcand_n;
      mplier     <= mplier_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      result     <= result_n;
      flag_carry <= carry_n;
      flag_ovf   <= ovf_n;
      flag_zero  <= zero_n;
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
module tb_param_seq_alu;

  localparam int W4 = 4;
  localparam int W8 = 8;

  logic        clk;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [3:0]  a, b;
  logic [7:0]  result;
  logic        flag_carry, flag_ovf, flag_zero;

  logic        rst8_n, in_valid_8, in_ready_8, out_valid_8, out_ready_8;
  logic [2:0]  op_8;
  logic [7:0]  a_8, b_8;
  logic [15:0] result_8;
  logic        flag_carry_8, flag_ovf_8, flag_zero_8;

  param_seq_alu #(.W(W4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
    .flag_zero(flag_zero)
  );

  param_seq_alu #(.W(W8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .op(op_8), .a(a_8), .b(b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .flag_carry(flag_carry_8), .flag_ovf(flag_ovf_8),
    .flag_zero(flag_zero_8)
  );

  typedef struct {
    logic [7:0] res;
    bit         c;
    bit         v;
    bit         z;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int opc, input int x, input int y);
    exp_t e;
    int full, half, sx, sy, r, s;
    full = 1 << W4;
    half = full / 2;
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    e.c = 0; e.v = 0; e.cyc = 0;
    r = 0;
    case (opc)
      0: begin r = x + y; s = sx + sy; e.c = (r >= full); e.v = (s >= half) || (s < -half); r = r % full; end
      1: begin r = x - y; s = sx - sy; e.c = (x < y); e.v = (s >= half) || (s < -half); if (r < 0) r += full; end
      2: begin r = (full - x) % full; e.v = (-sx >= half); end
      3: begin r = (full - y) % full; e.v = (-sy >= half); end
      4: begin r = x * y; e.v = (r >= full); end
      5: r = x & y;
      6: r = x | y;
      default: r = x ^ y;
    endcase
    e.res = r[7:0];
    e.z = (r == 0);
    return e;
  endfunction

  task automatic issue(input int opc, input int x, input int y, input bit rnd);
    exp_t e;
    int n = 0;
    bit done = 0;
    in_valid = 1'b1;
    op = 3'(opc);
    a = 4'(x);
    b = 4'(y);
    while (!done && n < 200) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        e = model(opc, x, y);
        e.cyc = cyc + 1 + ((opc == 4) ? W4 : 0);
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d actual=not_accepted required=accepted", opc);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=no_output", result);
      end else begin
        if (!lat_done) begin
          chk("latency_cycle", cyc, sb[0].cyc);
          lat_done = 1;
        end
        if (out_ready) begin
          chk("result", result, sb[0].res);
          chk("carry", flag_carry, sb[0].c);
          chk("ovf", flag_ovf, sb[0].v);
          chk("zero", flag_zero, sb[0].z);
          void'(sb.pop_front());
          lat_done = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 0; rst8_n = 0;
    in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;
    in_valid_8 = 0; op_8 = 0; a_8 = 0; b_8 = 0; out_ready_8 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_carry, flag_ovf, flag_zero}, 0);
    @(posedge clk);
    #1;
    rst_n = 1; rst8_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed cases through the scoreboard.
    issue(0, 9, 8, 0);
    issue(1, 3, 5, 0);
    issue(1, 5, 5, 0);
    drain();
    issue(4, 15, 15, 0);
    for (int i = 0; i < W4; i++) begin
      @(negedge clk);
      chk("mul_busy_in_ready", in_ready, 0);
    end
    @(negedge clk);
    chk("mul_done_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    issue(4, 0, 9, 0);
    issue(2, 8, 0, 0);
    issue(7, 10, 5, 0);
    drain();

    // Backpressure: held result, ignored request, then back-to-back.
    out_ready = 0;
    issue(0, 1, 1, 0);
    in_valid = 1; op = 3'd5; a = 4'hC; b = 4'hA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result_held", result, 8'h02);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    issue(5, 12, 10, 0);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15), 1);
      if ($urandom_range(0, 4) == 0) begin
        out_ready = $urandom_range(0, 1);
        @(posedge clk);
        #1;
      end
    end
    drain();

    // W=8: abort of a multiply by reset, then a clean multiply.
    in_valid_8 = 1; op_8 = 3'd0; a_8 = 8'd100; b_8 = 8'd50;
    @(negedge clk);
    chk("w8_in_ready", in_ready_8, 1);
    @(posedge clk);
    #1;
    in_valid_8 = 0;
    @(negedge clk);
    chk("w8_add_result", result_8, 16'd150);
    @(posedge clk);
    #1;
    in_valid_8 = 1; op_8 = 3'd4; a_8 = 8'd200; b_8 = 8'd3;
    @(posedge clk);
    #1;
    in_valid_8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("w8_mid_mul_in_ready", in_ready_8, 0);
    chk("w8_mid_mul_out_valid", out_valid_8, 0);
    #1;
    rst8_n = 0;
    #1;
    chk("w8_abort_out_valid", out_valid_8, 0);
    chk("w8_abort_result", result_8, 0);
    chk("w8_abort_flags", {flag_carry_8, flag_ovf_8, flag_zero_8}, 0);
    @(posedge clk);
    #1;
    rst8_n = 1;
    in_valid_8 = 1; op_8 = 3'd4; a_8 = 8'd200; b_8 = 8'd3;
    @(negedge clk);
    chk("w8_mul_accept", in_ready_8, 1);
    @(posedge clk);
    #1;
    in_valid_8 = 0;
    for (int i = 0; i < W8; i++) begin
      @(negedge clk);
      chk("w8_mul_not_yet_valid", out_valid_8, 0);
    end
    @(negedge clk);
    chk("w8_mul_valid", out_valid_8, 1);
    chk("w8_mul_result", result_8, 16'(200 * 3));
    chk("w8_mul_ovf", flag_ovf_8, 1);
    chk("w8_mul_carry", flag_carry_8, 0);
    chk("w8_mul_zero", flag_zero_8, 0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
